// File: rtl/sm_clk_pkg.sv
// Shared state and mode encodings for the divided clock generator.
package sm_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } clkState_t;

  // 2'b11 has no name and is treated as STOP by the generator.
  typedef enum logic [1:0] {
    STOP = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } clkMode_t;

  function automatic int unsigned debWidth(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sm_sync.sv
// Multi-stage flop synchronizer with asynchronous active-high reset.
module sm_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sm_clk_gen.sv
// Glitch-free programmable clock divider with run/stop/debounced single-step.
module sm_clk_gen
  import sm_clk_pkg::*;
#(
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic [DIV_W-1:0] divide,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic             clkOut,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] divActive
);

  localparam int unsigned DEB_W = debWidth(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DIV_W-1:0] divSync;
  logic [1:0]       modeSync;
  logic             stepSync;

  logic [DEB_W-1:0] debCnt;
  logic             stepAcc;
  logic             stepEvent;
  logic             stepPending;

  clkState_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] halfM1;
  logic [DIV_W-1:0] divQ, divNext;
  logic             enterHigh;
  logic             startCond;
  logic             clkOutQ, clkOutD;
  logic             tickQ, tickD;

  sm_sync #(.WIDTH(DIV_W), .STAGES(SYNC_STAGES)) uDivSync (
    .clk(clkIn), .rst(rst), .d(divide), .q(divSync)
  );

  sm_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) uModeSync (
    .clk(clkIn), .rst(rst), .d(mode), .q(modeSync)
  );

  sm_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) uStepSync (
    .clk(clkIn), .rst(rst), .d(step), .q(stepSync)
  );

  // A step event is the debounced level flipping 0->1 on this edge.
  assign stepEvent = stepSync && !stepAcc && (debCnt == DEB_LAST);

  // Debounce: the synced level must differ from the accepted one for DEB_CYCLES cycles.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      debCnt  <= '0;
      stepAcc <= 1'b0;
    end else if (stepSync == stepAcc) begin
      debCnt <= '0;
    end else if (debCnt == DEB_LAST) begin
      debCnt  <= '0;
      stepAcc <= stepSync;
    end else begin
      debCnt <= debCnt + DEB_W'(1);
    end
  end

  // Single-entry step queue; a same-cycle set wins over the clear on entering HIGH.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      stepPending <= 1'b0;
    end else if (stepEvent && (modeSync == RUN + 2'b01)) begin
      stepPending <= 1'b1;
    end else if (enterHigh) begin
      stepPending <= 1'b0;
    end
  end

  assign startCond = (modeSync == RUN) || stepPending;
  assign halfM1    = (CNT_W'(1) << (SHIFT + 32'(divQ))) - CNT_W'(1);

  // State register; clkOut and tick are flopped so they are glitch-free and reset asynchronously.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      divQ    <= '0;
      clkOutQ <= 1'b0;
      tickQ   <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      divQ    <= divNext;
      clkOutQ <= clkOutD;
      tickQ   <= tickD;
    end
  end

  // Next state: divide and mode are only sampled at a period boundary.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    divNext   = divQ;
    enterHigh = 1'b0;
    unique case (state)
      IDLE: begin
        cntNext = '0;
        if (startCond) begin
          stateNext = HIGH;
          enterHigh = 1'b1;
          divNext   = divSync;
        end
      end
      HIGH: begin
        if (cnt == halfM1) begin
          stateNext = LOW;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt == halfM1) begin
          cntNext = '0;
          if (startCond) begin
            stateNext = HIGH;
            enterHigh = 1'b1;
            divNext   = divSync;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs: registered clock/tick derive from the next state; running from the current one.
  always_comb begin
    clkOutD = (stateNext == HIGH);
    tickD   = enterHigh;
    running = (state != IDLE);
  end

  assign clkOut    = clkOutQ;
  assign tick      = tickQ;
  assign divActive = divQ;

endmodule
